// File: rtl/rv_wb_pkg.sv
// -----------------------------------------------------------------------------
// rv_wb_pkg
// Shared types and constants for the register-file writeback path.
//   WB_DATA_WIDTH    : register data width
//   WB_ADDRESS_WIDTH : register index width
//   WB_NUM_REGS      : number of architectural registers
//   wb_req_t         : one pending register write {rd, data}
//   X0               : index of the hard-wired zero register
// -----------------------------------------------------------------------------
package rv_wb_pkg;

    localparam int WB_DATA_WIDTH    = 32;
    localparam int WB_ADDRESS_WIDTH = 5;
    localparam int WB_NUM_REGS      = 32;

    typedef struct packed {
        logic [WB_ADDRESS_WIDTH-1:0] rd;
        logic [WB_DATA_WIDTH-1:0]    data;
    } wb_req_t;

    localparam logic [WB_ADDRESS_WIDTH-1:0] X0 = '0;

endpackage

// File: rtl/rf_writeback_arbiter_if.sv
// -----------------------------------------------------------------------------
// rf_writeback_arbiter_if
// Bundles the writeback sources (ALU, load) and the register-file write port.
//   master : the producer side (pipeline / bench) driving alu_* and ld_*
//   slave  : the arbiter, driving the write port, stall/ready and hazard mask
//
// Handshakes:
//   ALU  : alu_valid has no ready. While alu_stall is high the producer must
//          hold alu_valid low; a result offered anyway is dropped and flagged
//          on err_stall.
//   Load : a transfer happens on a posedge where ld_valid && ld_ready. Once
//          ld_valid is raised, ld_valid/ld_rd/ld_data stay stable until that
//          transfer. ld_ready depends only on registered state and rst.
// -----------------------------------------------------------------------------
interface rf_writeback_arbiter_if
    import rv_wb_pkg::*;
#(
    parameter int DATA_WIDTH    = WB_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = WB_ADDRESS_WIDTH,
    parameter int NUM_REGS      = WB_NUM_REGS
);

    logic                     alu_valid;
    logic [ADDRESS_WIDTH-1:0] alu_rd;
    logic [DATA_WIDTH-1:0]    alu_data;
    logic                     alu_stall;

    logic                     ld_valid;
    logic                     ld_ready;
    logic [ADDRESS_WIDTH-1:0] ld_rd;
    logic [DATA_WIDTH-1:0]    ld_data;

    logic                     rg_wrt_en;
    logic [ADDRESS_WIDTH-1:0] rg_wrt_dest;
    logic [DATA_WIDTH-1:0]    rg_wrt_data;

    logic [NUM_REGS-1:0]      pend_mask;
    logic                     err_stall;

    modport master (
        output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
        input  alu_stall, ld_ready, rg_wrt_en, rg_wrt_dest, rg_wrt_data,
               pend_mask, err_stall
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
        output alu_stall, ld_ready, rg_wrt_en, rg_wrt_dest, rg_wrt_data,
               pend_mask, err_stall
    );

endinterface

// File: rtl/wb_load_fifo.sv
// -----------------------------------------------------------------------------
// wb_load_fifo
// Pointer/count FIFO holding load results waiting for the write port.
//   clk, rst       : clock, synchronous active-high reset (empties the FIFO)
//   push_i         : write push_data_i at the tail (ignored when full)
//   push_data_i    : entry to enqueue
//   pop_i          : drop the head (ignored when empty)
//   head_o         : current head entry
//   full_o/empty_o : occupancy flags
//   count_o        : number of valid entries
//   entry_valid_o  : per physical slot, slot holds a queued entry
//   entry_rd_o     : per physical slot, destination register of that slot
// -----------------------------------------------------------------------------
module wb_load_fifo
    import rv_wb_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type req_t = wb_req_t,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   push_i,
    input  req_t                                   push_data_i,
    input  logic                                   pop_i,
    output req_t                                   head_o,
    output logic                                   full_o,
    output logic                                   empty_o,
    output logic [CW-1:0]                          count_o,
    output logic [DEPTH-1:0]                       entry_valid_o,
    output logic [DEPTH-1:0][WB_ADDRESS_WIDTH-1:0] entry_rd_o
);

    req_t          mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    // A slot is live when its distance from the head (mod DEPTH, DEPTH being a
    // power of two) is below the occupancy.
    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        logic [PW-1:0] off;
        assign off              = PW'(g) - rd_ptr_q;
        assign entry_valid_o[g] = ({1'b0, off} < count_q);
        assign entry_rd_o[g]    = mem_q[g].rd;
    end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// rf_writeback_arbiter
// Merges ALU results (single-cycle, not stallable except by alu_stall) and
// load results (valid/ready, buffered in a small FIFO) into the single
// register-file write port. Write-port outputs are registered on posedge so
// they are stable for the regfile's negedge write. Writes to x0 are dropped.
//   clk, rst    : clock, synchronous active-high reset
//   bus         : rf_writeback_arbiter_if slave (ALU, load, write port,
//                 alu_stall, pend_mask, err_stall)
//   lq_count_o  : load-queue occupancy, for observation
// -----------------------------------------------------------------------------
module rf_writeback_arbiter
    import rv_wb_pkg::*;
#(
    parameter int DATA_WIDTH    = WB_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = WB_ADDRESS_WIDTH,
    parameter int NUM_REGS      = WB_NUM_REGS,
    parameter int LQ_DEPTH      = 2,
    parameter int STARVE_MAX    = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    rf_writeback_arbiter_if.slave          bus,
    output logic [$clog2(LQ_DEPTH+1)-1:0]  lq_count_o
);

    localparam int CW = $clog2(LQ_DEPTH + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    wb_req_t                                  push_req;
    wb_req_t                                  head_req;
    logic                                     lq_full;
    logic                                     lq_empty;
    logic                                     lq_push;
    logic                                     lq_pop;
    logic [CW-1:0]                            lq_count;
    logic [LQ_DEPTH-1:0]                      lq_valid;
    logic [LQ_DEPTH-1:0][WB_ADDRESS_WIDTH-1:0] lq_rd;

    logic                     alu_win;
    logic [SW-1:0]            starve_q,    starve_d;
    logic                     alu_stall_q, alu_stall_d;
    logic                     err_stall_q, err_stall_d;
    logic                     rg_en_q,     rg_en_d;
    logic [ADDRESS_WIDTH-1:0] rg_dest_q,   rg_dest_d;
    logic [DATA_WIDTH-1:0]    rg_data_q,   rg_data_d;
    logic [NUM_REGS-1:0]      pend_mask;

    assign push_req = '{rd: bus.ld_rd, data: bus.ld_data};

    wb_load_fifo #(
        .DEPTH (LQ_DEPTH),
        .req_t (wb_req_t)
    ) u_lq (
        .clk           (clk),
        .rst           (rst),
        .push_i        (lq_push),
        .push_data_i   (push_req),
        .pop_i         (lq_pop),
        .head_o        (head_req),
        .full_o        (lq_full),
        .empty_o       (lq_empty),
        .count_o       (lq_count),
        .entry_valid_o (lq_valid),
        .entry_rd_o    (lq_rd)
    );

    // Ready comes from the registered count only: a full queue does not accept
    // even when the head is leaving this cycle.
    assign bus.ld_ready = !rst && !lq_full;

    // Loads to x0 complete the handshake but never occupy a slot.
    assign lq_push = bus.ld_valid && bus.ld_ready && (bus.ld_rd != X0);

    // ALU has priority unless stalled; an x0 ALU result leaves the port free.
    assign alu_win = !alu_stall_q && bus.alu_valid && (bus.alu_rd != X0);
    assign lq_pop  = !rst && !alu_win && !lq_empty;

    always_comb begin
        starve_d    = '0;
        alu_stall_d = 1'b0;
        err_stall_d = err_stall_q | (bus.alu_valid & alu_stall_q);
        rg_en_d     = 1'b0;
        rg_dest_d   = rg_dest_q;
        rg_data_d   = rg_data_q;

        if (alu_win) begin
            rg_en_d   = 1'b1;
            rg_dest_d = bus.alu_rd;
            rg_data_d = bus.alu_data;
        end else if (!lq_empty) begin
            rg_en_d   = 1'b1;
            rg_dest_d = head_req.rd;
            rg_data_d = head_req.data;
        end

        // Count ALU wins over a waiting load. The STARVE_MAX-th one raises
        // alu_stall for the next cycle, which forces the head out; any pop or
        // an empty queue leaves the counter at zero.
        if (alu_win && !lq_empty) begin
            if (starve_q == SW'(STARVE_MAX - 1)) begin
                alu_stall_d = 1'b1;
            end else begin
                starve_d = starve_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q    <= '0;
            alu_stall_q <= 1'b0;
            err_stall_q <= 1'b0;
            rg_en_q     <= 1'b0;
            rg_dest_q   <= '0;
            rg_data_q   <= '0;
        end else begin
            starve_q    <= starve_d;
            alu_stall_q <= alu_stall_d;
            err_stall_q <= err_stall_d;
            rg_en_q     <= rg_en_d;
            rg_dest_q   <= rg_dest_d;
            rg_data_q   <= rg_data_d;
        end
    end

    // Hazard mask over queued loads; x0 can never be pending.
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            if (lq_valid[i]) pend_mask[lq_rd[i]] = 1'b1;
        end
        pend_mask[0] = 1'b0;
    end

    assign bus.alu_stall   = alu_stall_q;
    assign bus.err_stall   = err_stall_q;
    assign bus.rg_wrt_en   = rg_en_q;
    assign bus.rg_wrt_dest = rg_dest_q;
    assign bus.rg_wrt_data = rg_data_q;
    assign bus.pend_mask   = pend_mask;
    assign lq_count_o      = lq_count;

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_writeback_arbiter
// Directed scenarios followed by random traffic. A queue-based reference model
// predicts every register write (pushed into exp_q) and the per-cycle values
// of ld_ready, alu_stall, err_stall, pend_mask and the queue occupancy; a
// negedge monitor compares the DUT against them.
// -----------------------------------------------------------------------------
module tb_rf_writeback_arbiter;
    import rv_wb_pkg::*;

    localparam int AW         = 5;
    localparam int DW         = 32;
    localparam int NR         = 32;
    localparam int LQ_DEPTH   = 2;
    localparam int STARVE_MAX = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rf_writeback_arbiter_if bus ();
    logic [1:0] lq_count;

    rf_writeback_arbiter #(
        .LQ_DEPTH   (LQ_DEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .lq_count_o (lq_count)
    );

    // ---------------- reference model state ----------------
    wb_req_t          m_q[$];
    int               m_starve = 0;
    bit               m_stall  = 0;
    bit               m_err    = 0;
    bit               m_wr_en  = 0;
    logic [AW+DW-1:0] exp_q[$];

    // Expectations for the cycle currently in progress
    bit          chk_en = 0;
    bit          cur_ready, cur_stall, cur_err, cur_en;
    logic [NR-1:0] cur_pend;
    int          cur_count;

    // Pending load offered on the load port, held until accepted
    bit          pl_v = 0;
    logic [AW-1:0] pl_rd = '0;
    logic [DW-1:0] pl_data = '0;
    bit          allow_err = 0;

    int n_checks = 0;
    int n_pass   = 0;
    logic [DW-1:0] rf [NR];
    logic [AW+DW:0] snap;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [NR-1:0] model_pend();
        logic [NR-1:0] mask;
        mask = '0;
        foreach (m_q[i]) mask |= (NR'(1) << m_q[i].rd);
        mask[0] = 1'b0;
        return mask;
    endfunction

    task automatic model_step(input bit av, input logic [AW-1:0] ard, input logic [DW-1:0] adata);
        bit      accept, win, nonempty;
        wb_req_t w;
        if (rst) begin
            m_q.delete();
            m_starve = 0;
            m_stall  = 0;
            m_err    = 0;
            m_wr_en  = 0;
            pl_v     = 0;
        end else begin
            accept   = pl_v && (m_q.size() < LQ_DEPTH);
            win      = !m_stall && av && (ard != 0);
            nonempty = (m_q.size() > 0);
            if (m_stall && av) m_err = 1;
            m_wr_en = 0;
            if (win) begin
                exp_q.push_back({ard, adata});
                m_wr_en = 1;
            end else if (nonempty) begin
                w = m_q.pop_front();
                exp_q.push_back({w.rd, w.data});
                m_wr_en = 1;
            end
            if (accept) begin
                if (pl_rd != 0) m_q.push_back('{rd: pl_rd, data: pl_data});
                pl_v = 0;
            end
            if (win && nonempty) m_starve++;
            else m_starve = 0;
            m_stall = (m_starve == STARVE_MAX);
            if (m_stall) m_starve = 0;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic offer_load(input logic [AW-1:0] rd, input logic [DW-1:0] data);
        pl_v    = 1;
        pl_rd   = rd;
        pl_data = data;
    endtask

    // Called just after a posedge: drives one cycle of inputs, publishes what
    // the DUT should show during this cycle, advances the model to the next edge.
    task automatic cycle(input bit av, input logic [AW-1:0] ard, input logic [DW-1:0] adata);
        if (m_stall && !allow_err) av = 0;
        bus.alu_valid = av;
        bus.alu_rd    = ard;
        bus.alu_data  = adata;
        bus.ld_valid  = pl_v;
        bus.ld_rd     = pl_rd;
        bus.ld_data   = pl_data;
        cur_ready = !rst && (m_q.size() < LQ_DEPTH);
        cur_stall = m_stall;
        cur_err   = m_err;
        cur_en    = m_wr_en;
        cur_pend  = model_pend();
        cur_count = m_q.size();
        model_step(av, ard, adata);
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(posedge clk) begin
        #1;
        snap = {bus.rg_wrt_en, bus.rg_wrt_dest, bus.rg_wrt_data};
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("ld_ready",  64'(bus.ld_ready),  64'(cur_ready));
            check("alu_stall", 64'(bus.alu_stall), 64'(cur_stall));
            check("err_stall", 64'(bus.err_stall), 64'(cur_err));
            check("pend_mask", 64'(bus.pend_mask), 64'(cur_pend));
            check("lq_count",  64'(lq_count),      64'(cur_count));
            check("lq_count_bound", 64'(lq_count <= 2'(LQ_DEPTH)), 64'(1));
            check("rg_wrt_en", 64'(bus.rg_wrt_en), 64'(cur_en));
            check("wr_stable", 64'({bus.rg_wrt_en, bus.rg_wrt_dest, bus.rg_wrt_data}), 64'(snap));
            if (bus.rg_wrt_en) begin
                check("wr_dest_nonzero", 64'(bus.rg_wrt_dest != 0), 64'(1));
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL wr_unexpected: got dest %0d data %0h expected no write",
                             bus.rg_wrt_dest, bus.rg_wrt_data);
                end else begin
                    check("wr_dest_data", 64'({bus.rg_wrt_dest, bus.rg_wrt_data}), 64'(exp_q.pop_front()));
                end
                rf[bus.rg_wrt_dest] = bus.rg_wrt_data;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int nl;
        bus.alu_valid = 0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.ld_valid  = 0; bus.ld_rd  = '0; bus.ld_data  = '0;
        foreach (rf[i]) rf[i] = '0;
        rst = 1;
        @(posedge clk);
        #1;
        chk_en = 1;
        rst    = 0;

        check("reset_en",   64'(bus.rg_wrt_en),   64'(0));
        check("reset_dest", 64'(bus.rg_wrt_dest), 64'(0));
        check("reset_data", 64'(bus.rg_wrt_data), 64'(0));

        // 1: fill queue with two loads behind ALU traffic, then reset
        offer_load(5'd4, 32'hA0A0_0004);
        cycle(1, 5'd1, 32'h1111_0001);
        offer_load(5'd6, 32'hA0A0_0006);
        cycle(1, 5'd1, 32'h1111_0002);
        check("t1_full_count", 64'(lq_count), 64'(2));
        rst = 1;
        cycle(0, '0, '0);
        rst = 0;
        check("t1_rst_count", 64'(lq_count),      64'(0));
        check("t1_rst_pend",  64'(bus.pend_mask), 64'(0));
        check("t1_rst_en",    64'(bus.rg_wrt_en), 64'(0));
        check("t1_rst_dest",  64'(bus.rg_wrt_dest), 64'(0));

        // 2: plain ALU write
        cycle(1, 5'd5, 32'hDEAD_BEEF);
        check("t2_dest", 64'(bus.rg_wrt_dest), 64'(5));
        check("t2_data", 64'(bus.rg_wrt_data), 64'(32'hDEAD_BEEF));
        cycle(0, '0, '0);
        check("t2_reg5", 64'(rf[5]), 64'(32'hDEAD_BEEF));

        // 3: ALU and load on the same edge
        offer_load(5'd7, 32'h0000_1234);
        cycle(1, 5'd3, 32'h0000_AAAA);
        check("t3_alu_first", 64'(bus.rg_wrt_dest), 64'(3));
        check("t3_pend7",     64'(bus.pend_mask[7]), 64'(1));
        cycle(0, '0, '0);
        check("t3_ld_dest", 64'(bus.rg_wrt_dest), 64'(7));
        check("t3_ld_data", 64'(bus.rg_wrt_data), 64'(32'h0000_1234));
        check("t3_pend_clr", 64'(bus.pend_mask), 64'(0));

        // 4: three back-to-back loads against continuous ALU traffic
        nl = 0;
        for (int i = 0; i < 6; i++) begin
            if (!pl_v && nl < 3) begin
                offer_load(5'(9 + nl), 32'hC000_0000 + 32'(nl));
                nl++;
            end
            cycle(1, 5'(20 + i), $urandom);
            if (i == 1) check("t4_not_ready", 64'(bus.ld_ready), 64'(0));
            if (i == 4) check("t4_stall",     64'(bus.alu_stall), 64'(1));
            if (i == 5) check("t4_first_ld",  64'(bus.rg_wrt_dest), 64'(9));
        end
        repeat (4) cycle(0, '0, '0);

        // 5: x0 from both sources, then ALU during a stall pulse
        offer_load(5'd0, 32'hFFFF_FFFF);
        cycle(1, 5'd0, 32'hEEEE_EEEE);
        check("t5_x0_no_write", 64'(bus.rg_wrt_en), 64'(0));
        offer_load(5'd12, 32'h0000_0C0C);
        for (int i = 0; i < 5; i++) cycle(1, 5'(24 + i), $urandom);
        allow_err = 1;
        cycle(1, 5'd15, 32'h0BAD_0BAD);
        allow_err = 0;
        check("t5_err",        64'(bus.err_stall),   64'(1));
        check("t5_drop_alu",   64'(bus.rg_wrt_dest), 64'(12));
        repeat (3) cycle(0, '0, '0);
        check("t5_err_sticky", 64'(bus.err_stall),   64'(1));
        rst = 1;
        cycle(0, '0, '0);
        rst = 0;
        check("t5_err_clr", 64'(bus.err_stall), 64'(0));

        // random traffic
        for (int i = 0; i < 400; i++) begin
            if (!pl_v && $urandom_range(0, 1) == 1)
                offer_load(5'($urandom_range(0, 31)), $urandom);
            rst = ($urandom_range(0, 99) == 0);
            cycle($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom);
        end
        rst = 0;
        repeat (8) cycle(0, '0, '0);
        check("exp_q_drained", 64'(exp_q.size()), 64'(0));

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish by 200000");
        $fatal(1);
    end

endmodule
